// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: FSM state encoding and ALU opcodes.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    GET_B    = 3'd1,
    GET_OP   = 3'd2,
    ISSUE    = 3'd3,
    WAIT_ACK = 3'd4,
    SHOW     = 3'd5
  } seq_state_t;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_RCA  = 3'd0;
  localparam logic [OP_W-1:0] OP_CLA  = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
  localparam logic [OP_W-1:0] OP_AND  = 3'd3;
  localparam logic [OP_W-1:0] OP_OR   = 3'd4;
  localparam logic [OP_W-1:0] OP_PASS = 3'd5;

  // States in which an ENTER press has an effect; elsewhere presses are dropped.
  function automatic logic takes_press(seq_state_t s);
    return (s == GET_A) || (s == GET_B) || (s == GET_OP) || (s == SHOW);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ENTER button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  // cnt counts consecutive synchronized samples that disagree with the current level;
  // the level flips on the DEBOUNCE_CYCLES-th one, and the press fires on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Switch/button front end for the board ALU: gathers A, B, opcode, runs the req/ack handshake.
// Optional feature macro: ACC_CHAIN_EN (reuse low half of a good result as the next operand A).
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   sw_data,
  input  logic [2:0]         sw_op,
  input  logic               btn_enter,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  output logic               alu_req,
  input  logic               alu_ack,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic [2*WIDTH-1:0] result_q,
  output logic               result_valid,
  output logic               err,
  output logic [2:0]         state_dbg
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  seq_state_t    state, state_nxt;
  logic          press, press_ok;
  logic [TW-1:0] tmo_cnt;
  logic          ack_hit, tmo_hit, chain;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_enter),
    .press   (press)
  );

  assign press_ok = press && takes_press(state);
  assign ack_hit  = (state == WAIT_ACK) && alu_ack;
  // Ack takes priority: a timeout only counts when no ack arrives in that same cycle.
  assign tmo_hit  = (state == WAIT_ACK) && !alu_ack && (tmo_cnt == TW'(ACK_TIMEOUT - 1));

`ifdef ACC_CHAIN_EN
  assign chain = result_valid && !err;
`else
  assign chain = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= GET_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:    if (press_ok) state_nxt = GET_B;
      GET_B:    if (press_ok) state_nxt = GET_OP;
      GET_OP:   if (press_ok) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_hit || tmo_hit) state_nxt = SHOW;
      SHOW:     if (press_ok) state_nxt = chain ? GET_B : GET_A;
      default:  state_nxt = GET_A;
    endcase
  end

  // Operands only move on their own latching press, so they are frozen while alu_req=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      alu_req      <= 1'b0;
      result_q     <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      case (state)
        GET_A:  if (press_ok) alu_a  <= sw_data;
        GET_B:  if (press_ok) alu_b  <= sw_data;
        GET_OP: if (press_ok) alu_op <= sw_op;
        ISSUE: begin
          alu_req      <= 1'b1;
          result_q     <= '0;
          result_valid <= 1'b0;
          err          <= 1'b0;
          tmo_cnt      <= '0;
        end
        WAIT_ACK: begin
          if (ack_hit) begin
            result_q     <= alu_result;
            result_valid <= 1'b1;
            alu_req      <= 1'b0;
          end else if (tmo_hit) begin
            result_q <= '0;
            err      <= 1'b1;
            alu_req  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SHOW:    if (press_ok && chain) alu_a <= result_q[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a transaction-level reference model.
module tb_alu_operand_sequencer;

  localparam int W  = 4;
  localparam int DB = 4;
  localparam int TO = 8;
`ifdef ACC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   sw_data;
  logic [2:0]     sw_op;
  logic           btn_enter;
  logic [W-1:0]   alu_a, alu_b;
  logic [2:0]     alu_op;
  logic           alu_req, alu_ack;
  logic [2*W-1:0] alu_result, result_q;
  logic           result_valid, err;
  logic [2:0]     state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the operator has entered and what the display should hold.
  logic [W-1:0]   m_a, m_b;
  logic [2:0]     m_op;
  logic [2*W-1:0] m_res;
  logic           m_valid, m_err;
  int             m_st;  // 0 GET_A, 1 GET_B, 2 GET_OP, 3 ISSUE, 4 WAIT_ACK, 5 SHOW

  always #5 clk = ~clk;

  alu_operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_data      (sw_data),
    .sw_op        (sw_op),
    .btn_enter    (btn_enter),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_req      (alu_req),
    .alu_ack      (alu_ack),
    .alu_result   (alu_result),
    .result_q     (result_q),
    .result_valid (result_valid),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0; m_err = 1'b0; m_st = 0;
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.alu_a", tag),        32'(alu_a),        32'(m_a));
    chk($sformatf("%s.alu_b", tag),        32'(alu_b),        32'(m_b));
    chk($sformatf("%s.alu_op", tag),       32'(alu_op),       32'(m_op));
    chk($sformatf("%s.alu_req", tag),      32'(alu_req),      32'(m_st == 4));
    chk($sformatf("%s.result_q", tag),     32'(result_q),     32'(m_res));
    chk($sformatf("%s.result_valid", tag), 32'(result_valid), 32'(m_valid));
    chk($sformatf("%s.err", tag),          32'(err),          32'(m_err));
    chk($sformatf("%s.state", tag),        32'(state_dbg),    32'(m_st));
  endtask

  // Operator action: what an accepted press means at the current point of the dialogue.
  task automatic model_press(input logic [W-1:0] v, input logic [2:0] op);
    case (m_st)
      0: begin m_a = v; m_st = 1; end
      1: begin m_b = v; m_st = 2; end
      2: begin m_op = op; m_st = 3; end
      5: begin
        if (CHAIN && m_valid) begin m_a = m_res[W-1:0]; m_st = 1; end
        else m_st = 0;
      end
      default: ;
    endcase
  endtask

  // Clean press: settle low long enough for release, hold, then one edge for the FSM to act.
  task automatic press(input logic [W-1:0] v, input logic [2:0] op);
    sw_data   = v;
    sw_op     = op;
    btn_enter = 1'b0;
    steps(DB + 4);
    btn_enter = 1'b1;
    steps(DB + 2);
    btn_enter = 1'b0;
    step();
    sw_data = W'($urandom);
    sw_op   = 3'($urandom);
    model_press(v, op);
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    if (m_st == 0) press(a, 3'($urandom));
    press(b, 3'($urandom));
    press(W'($urandom), op);
  endtask

  // ALU responder: ack in wait cycle d (d >= TO means never); checks req duration and stability.
  task automatic run_txn(input int d, input logic [2*W-1:0] res, input string tag);
    int cnt = 0;
    bit stable = 1'b1;
    chk($sformatf("%s.issue_state", tag), 32'(state_dbg), 32'd3);
    step();
    m_valid = 1'b0; m_err = 1'b0; m_res = '0; m_st = 4;
    chk($sformatf("%s.req_up", tag), 32'(alu_req), 32'd1);
    chk($sformatf("%s.valid_clr", tag), 32'(result_valid), 32'd0);
    for (int c = 0; c < TO + 4; c++) begin
      if (!alu_req) break;
      cnt++;
      if (alu_a !== m_a || alu_b !== m_b || alu_op !== m_op) stable = 1'b0;
      alu_ack    = (c == d);
      alu_result = (c == d) ? res : 2*W'($urandom);
      step();
      alu_ack = 1'b0;
    end
    if (d < TO) begin m_res = res; m_valid = 1'b1; end
    else        begin m_err = 1'b1; end
    m_st = 5;
    chk($sformatf("%s.req_cycles", tag), 32'(cnt), 32'((d < TO) ? d + 1 : TO));
    chk($sformatf("%s.op_stable", tag), 32'(stable), 32'd1);
    check_all(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bounce;
    logic [2*W-1:0] r;
    reset = 1'b1; btn_enter = 1'b0; alu_ack = 1'b0; alu_result = '0;
    sw_data = '0; sw_op = '0;
    model_reset();
    @(negedge clk);
    steps(2);
    check_all("reset");
    reset = 1'b0;
    step();

    // Directed transaction: A=3, B=5, op 0, ack two cycles after req.
    load(4'd3, 4'd5, 3'd0);
    run_txn(2, 8'h08, "t1");

    // Debounce: short pulse and bouncing input must not register in SHOW.
    steps(DB + 4);
    btn_enter = 1'b1; steps(3); btn_enter = 1'b0; steps(DB + 6);
    chk("pulse3.state", 32'(state_dbg), 32'd5);
    bounce = 8'b01101011;
    for (int i = 0; i < 8; i++) begin btn_enter = bounce[i]; step(); end
    btn_enter = 1'b0; steps(DB + 6);
    chk("bounce.state", 32'(state_dbg), 32'd5);

    // Press latency: nothing after 2+DB edges, state moves on the following one.
    btn_enter = 1'b1;
    steps(DB + 2);
    chk("latency.before", 32'(state_dbg), 32'd5);
    step();
    btn_enter = 1'b0;
    model_press(W'($urandom), 3'($urandom));
    check_all("show_exit");

    // Timeout: no ack at all.
    load(W'($urandom), W'($urandom), 3'($urandom));
    run_txn(TO + 3, 8'hFF, "timeout");
    press(W'($urandom), 3'($urandom));
    check_all("after_timeout");

    // Ack arriving in the last allowed cycle wins over the timeout.
    load(W'($urandom), W'($urandom), 3'($urandom));
    run_txn(TO - 1, 8'hC3, "ack_last");
    press(W'($urandom), 3'($urandom));

    // Press during WAIT_ACK is dropped; ack in cycle TO-1 still completes.
    load(W'($urandom), W'($urandom), 3'($urandom));
    step();
    m_valid = 1'b0; m_err = 1'b0; m_res = '0; m_st = 4;
    sw_data = ~m_a; sw_op = ~m_op;
    btn_enter = 1'b1; steps(DB + 1); btn_enter = 1'b0; steps(2);
    check_all("wait_press");
    r = 2*W'($urandom);
    alu_ack = 1'b1; alu_result = r; step(); alu_ack = 1'b0;
    m_res = r; m_valid = 1'b1; m_st = 5;
    check_all("wait_press_ack");

    // Stray ack outside a transaction is ignored.
    press(W'($urandom), 3'($urandom));
    if (m_st == 0) press(W'($urandom), 3'($urandom));
    alu_ack = 1'b1; alu_result = 8'hFF; steps(3); alu_ack = 1'b0;
    check_all("stray_ack");
    press(W'($urandom), 3'($urandom));
    press(W'($urandom), 3'($urandom));
    run_txn(0, 8'h5A, "ack0");

    // Randomized transactions, including timeouts.
    for (int n = 0; n < 8; n++) begin
      press(W'($urandom), 3'($urandom));
      load(W'($urandom), W'($urandom), 3'($urandom));
      run_txn(int'($urandom_range(0, TO + 3)), 2*W'($urandom), $sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of WAIT_ACK.
    press(W'($urandom), 3'($urandom));
    load(W'($urandom | 1), W'($urandom), 3'($urandom));
    steps(2);
    chk("pre_reset.req", 32'(alu_req), 32'd1);
    #1 reset = 1'b1;
    #2;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    step();
    load(W'($urandom), W'($urandom), 3'($urandom));
    run_txn(1, 2*W'($urandom), "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
